// File: rtl/p2s_pkg.sv
// Shared constants, state encoding and the payload escape helper for the
// three-word serial frame transmitter.
package p2s_pkg;

  localparam int WORD_W = 14;
  localparam logic [WORD_W-1:0] HEADER_WORD = 14'h0FFF;
  localparam logic [WORD_W-1:0] HEADER_ESC  = 14'h0FFE;

  localparam logic [1:0] LAST_WORD = 2'd2;
  localparam logic [3:0] MSB_IDX   = 4'd13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2,
    GAP   = 2'd3
  } p2s_state_e;

  // A payload word that looks like a header would resynchronise the far end
  // onto the wrong word, so it is nudged by one LSB.
  function automatic logic [WORD_W-1:0] escape_payload(input logic [WORD_W-1:0] w);
    return (w == HEADER_WORD) ? HEADER_ESC : w;
  endfunction

endpackage

// File: rtl/p2s_bit_timer.sv
// Half-period timer for the serial clock. A down-counter reloads with
// CLK_DIV-1 and produces a tick on terminal count; the phase flop is the
// sck line itself, so it only toggles while sck_en is set.
module p2s_bit_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  input  logic sck_en,
  output logic tick,
  output logic phase
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == '0);

  // Count half-periods while running; park reloaded with sck low otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= RELOAD;
      phase <= 1'b0;
    end else if (!run) begin
      cnt   <= RELOAD;
      phase <= 1'b0;
    end else if (cnt == '0) begin
      cnt <= RELOAD;
      if (sck_en) begin
        phase <= ~phase;
      end else begin
        phase <= 1'b0;
      end
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/p2s_tx.sv
// Three-word serial frame transmitter: header, data_a, data_b, each sent
// MSB first with its own cs-low window. Every output comes straight from a
// flop because sck and cs clock the far-end receiver.
//
// state | meaning
// IDLE  | waiting for start; cs high, sck low
// SHIFT | shifting 14 bits, CLK_DIV low then CLK_DIV high per bit
// TAIL  | sck low, cs still low for CLK_DIV cycles after bit 0
// GAP   | cs high for CS_HIGH cycles; loads next word or ends frame
module p2s_tx
  import p2s_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_HIGH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [WORD_W-1:0] data_a,
  input  logic [WORD_W-1:0] data_b,
  output logic              busy,
  output logic              done,
  output logic              sck,
  output logic              mosi,
  output logic              cs
);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("p2s_tx: CLK_DIV must be 1 or more");
  end
  if (CS_HIGH < 3) begin : g_bad_cs_high
    $error("p2s_tx: CS_HIGH must be 3 or more");
  end

  localparam int GW = $clog2(CS_HIGH);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(CS_HIGH - 1);

  p2s_state_e        state;
  logic [1:0]        word_idx;
  logic [3:0]        bit_idx;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] pay_a;
  logic [WORD_W-1:0] pay_b;
  logic [GW-1:0]     gap_cnt;
  logic [WORD_W-1:0] next_word;
  logic              tmr_run;
  logic              tmr_sck_en;
  logic              tick;

  assign tmr_run    = (state == SHIFT) || (state == TAIL);
  assign tmr_sck_en = (state == SHIFT);
  assign next_word  = (word_idx == 2'd0) ? pay_a : pay_b;

  p2s_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_bit_timer (
    .clk   (clk),
    .rstn  (rstn),
    .run   (tmr_run),
    .sck_en(tmr_sck_en),
    .tick  (tick),
    .phase (sck)
  );

  // Frame sequencer: word/bit indices, shift register, cs/mosi/busy/done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      word_idx <= 2'd0;
      bit_idx  <= 4'd0;
      shreg    <= '0;
      pay_a    <= '0;
      pay_b    <= '0;
      gap_cnt  <= '0;
      cs       <= 1'b1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pay_a    <= escape_payload(data_a);
            pay_b    <= escape_payload(data_b);
            shreg    <= HEADER_WORD;
            mosi     <= HEADER_WORD[WORD_W-1];
            bit_idx  <= MSB_IDX;
            word_idx <= 2'd0;
            cs       <= 1'b0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // End of a high phase: this edge drives sck low, so mosi may move.
          if (tick && sck) begin
            if (bit_idx == 4'd0) begin
              state <= TAIL;
            end else begin
              bit_idx <= bit_idx - 4'd1;
              shreg   <= {shreg[WORD_W-2:0], 1'b0};
              mosi    <= shreg[WORD_W-2];
            end
          end
        end
        TAIL: begin
          if (tick) begin
            cs      <= 1'b1;
            gap_cnt <= GAP_RELOAD;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            if (word_idx == LAST_WORD) begin
              word_idx <= 2'd0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              word_idx <= word_idx + 2'd1;
              shreg    <= next_word;
              mosi     <= next_word[WORD_W-1];
              bit_idx  <= MSB_IDX;
              cs       <= 1'b0;
              state    <= SHIFT;
            end
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
